mod503_chunk_seq: RTL and testbench

- Sequential controller that time-multiplexes one shared 6-in/9-out residue lookup table (mod 503) across the 6-bit chunks of a wide operand.
- Steps chunk index k = 0..NCHUNK-1, drives the table, and accumulates the 9-bit partial residues modulo 503.
- Emits the final residue over a valid/ready handshake.
- Sits between the operand source and the downstream modular arithmetic, replacing NCHUNK parallel table instances and their adder tree.

---
 rtl/mod503_chunk_seq.sv | 113 +++++++++++
 tb/tb_mod503_chunk_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod503_chunk_seq.sv
// Chunk-serial residue (mod 503) controller sharing one 6-in/9-out lookup table.
// Walks the operand chunks, accumulates table residues mod MOD, then hands the result downstream.
module mod503_chunk_seq #(
    parameter int W_IN   = 36,
    parameter int CHUNK  = 6,
    parameter int NCHUNK = W_IN / CHUNK,
    parameter int MOD    = 503,
    parameter int RW     = 9,
    parameter int KW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN-1:0]   in_data,
    input  logic              flush,
    output logic              lut_en,
    output logic [KW-1:0]     lut_sel,
    output logic [CHUNK-1:0]  lut_x,
    input  logic [RW-1:0]     lut_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_res,
    output logic              out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
    localparam logic [RW:0]   MOD_W  = (RW + 1)'(MOD);
    localparam logic [RW-1:0] MOD_R  = RW'(MOD);

    state_e           state_q, state_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [W_IN-1:0]  opnd_q, opnd_d;
    logic             err_q, err_d;
    logic [RW:0]      sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            opnd_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            opnd_q  <= opnd_d;
            err_q   <= err_d;
        end
    end

    // Both addends are below 2^RW, so one conditional subtraction keeps acc in range
    // whenever every table residue was legal.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        opnd_d  = opnd_q;
        err_d   = err_q;
        sum     = {1'b0, acc_q} + {1'b0, lut_z};

        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            k_d     = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opnd_d  = in_data;
                        acc_d   = '0;
                        k_d     = '0;
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = (sum >= MOD_W) ? RW'(sum - MOD_W) : sum[RW-1:0];
                    err_d = err_q | (lut_z >= MOD_R);
                    if (k_q == K_LAST) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign lut_en    = (state_q == RUN);
    assign lut_sel   = lut_en ? k_q : '0;
    assign lut_x     = lut_en ? opnd_q[CHUNK*int'(k_q) +: CHUNK] : '0;
    assign out_valid = (state_q == DONE);
    assign out_res   = out_valid ? acc_q : '0;
    assign out_err   = out_valid & err_q;

endmodule

// File: tb/tb_mod503_chunk_seq.sv
// Self-checking bench for mod503_chunk_seq: mock residue table, vector table,
// randomized operands against plain modular arithmetic, and corner sequences.
module tb_mod503_chunk_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_data;
    logic        flush;
    logic        lut_en;
    logic [2:0]  lut_sel;
    logic [5:0]  lut_x;
    logic [8:0]  lut_z;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_res;
    logic        out_err;

    int mockMode;
    int totalChecks;
    int passChecks;

    typedef struct {
        logic [35:0] data;
        int          mode;
        logic [8:0]  expRes;
        logic        expErr;
        logic        checkRes;
    } vec_t;

    vec_t vecs[8];

    mod503_chunk_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .lut_en    (lut_en),
        .lut_sel   (lut_sel),
        .lut_x     (lut_x),
        .lut_z     (lut_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock table: chunk value weighted by its position, 64^k, reduced mod 503.
    function automatic int lutModel(input int mode, input int sel, input int x);
        int p;
        int z;
        p = 1;
        for (int i = 0; i < sel; i++) p = (p * 64) % 503;
        z = (x * p) % 503;
        if (mode == 1) z = 502;
        if (mode == 2 && sel == 3) z = 511;
        return z;
    endfunction

    always_comb lut_z = 9'(lutModel(mockMode, int'(lut_sel), int'(lut_x)));

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalChecks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            passChecks++;
        end
    endtask

    task automatic applyStimulus(input logic [35:0] data, input int mode);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready wait", in_ready, 1);
        mockMode = mode;
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runOperand(input logic [35:0] data, input int mode, input logic [8:0] expRes,
                              input logic expErr, input logic checkRes, input logic consume);
        int enCount;
        int latency;
        enCount = 0;
        latency = 0;
        applyStimulus(data, mode);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (lut_en) begin
                checkOutput("lut_sel", lut_sel, enCount);
                checkOutput("lut_x", lut_x, (data >> (6 * enCount)) & 36'd63);
                enCount++;
            end
            if (out_valid) begin
                latency = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("latency", latency, 7);
        checkOutput("lut_en count", enCount, 6);
        if (checkRes) checkOutput("out_res", out_res, expRes);
        checkOutput("out_err", out_err, expErr);
        checkOutput("in_ready in DONE", in_ready, 0);
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checkOutput("out_valid after consume", out_valid, 0);
            checkOutput("in_ready after consume", in_ready, 1);
        end
    endtask

    task automatic waitForSel(input logic [2:0] sel);
        int waited;
        waited = 0;
        while (!(lut_en && lut_sel == sel) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reach RUN chunk", lut_sel, sel);
    endtask

    task automatic watchNoResult(input string name);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        checkOutput(name, pulses, 0);
    endtask

    initial begin
        logic [35:0] rndData;
        longint unsigned rndRes;

        totalChecks = 0;
        passChecks  = 0;
        mockMode    = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        vecs[0] = '{36'd1000, 0, 9'd497, 1'b0, 1'b1};
        vecs[1] = '{36'd503,  0, 9'd0,   1'b0, 1'b1};
        vecs[2] = '{36'd1011, 0, 9'd5,   1'b0, 1'b1};
        vecs[3] = '{36'd0,    0, 9'd0,   1'b0, 1'b1};
        vecs[4] = '{36'h9_ABCD_1234, 1, 9'd497, 1'b0, 1'b1};
        vecs[5] = '{36'd1000, 2, 9'd0,   1'b1, 1'b0};
        vecs[6] = '{36'd1000, 0, 9'd497, 1'b0, 1'b1};
        vecs[7] = '{36'hF_FFFF_FFFF, 0, 9'(64'hF_FFFF_FFFF % 64'd503), 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset lut_en", lut_en, 0);
        checkOutput("reset lut_sel", lut_sel, 0);
        checkOutput("reset lut_x", lut_x, 0);
        checkOutput("reset out_res", out_res, 0);
        checkOutput("reset out_err", out_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            runOperand(vecs[v].data, vecs[v].mode, vecs[v].expRes, vecs[v].expErr, vecs[v].checkRes, 1'b1);
        end

        for (int r = 0; r < 20; r++) begin
            rndData = {4'($urandom_range(15, 0)), 32'($urandom)};
            rndRes  = 64'(rndData) % 64'd503;
            runOperand(rndData, 0, 9'(rndRes), 1'b0, 1'b1, 1'b1);
        end

        $display("[TB] backpressure sequence");
        runOperand(36'd1011, 0, 9'd5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold out_valid", out_valid, 1);
            checkOutput("hold out_res", out_res, 5);
            checkOutput("hold out_err", out_err, 0);
            checkOutput("hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("idle after release", in_ready, 1);
        mockMode = 0;
        in_valid = 1'b1;
        in_data  = 36'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("accepted next cycle lut_en", lut_en, 1);
        checkOutput("accepted next cycle lut_sel", lut_sel, 0);
        repeat (6) @(negedge clk);
        checkOutput("post-backpressure out_valid", out_valid, 1);
        checkOutput("post-backpressure out_res", out_res, 497);

        $display("[TB] result consumed while new operand offered");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 36'd77;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("DONE ignores operand in_ready", in_ready, 1);
        checkOutput("DONE ignores operand lut_en", lut_en, 0);
        @(negedge clk);
        checkOutput("DONE ignores operand still idle", lut_en, 0);

        $display("[TB] flush with in_valid in IDLE");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 36'd1000;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush blocks accept lut_en", lut_en, 0);
        checkOutput("flush blocks accept in_ready", in_ready, 1);

        $display("[TB] reset mid-run");
        applyStimulus(36'd1000, 0);
        waitForSel(3'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset in_ready", in_ready, 1);
        checkOutput("async reset lut_en", lut_en, 0);
        checkOutput("async reset out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watchNoResult("no result after reset");

        $display("[TB] flush mid-run");
        applyStimulus(36'd1011, 0);
        waitForSel(3'd4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush in_ready", in_ready, 1);
        checkOutput("flush lut_en", lut_en, 0);
        watchNoResult("no result after flush");

        runOperand(36'd1011, 0, 9'd5, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
